cla_linear_part: RTL and testbench

//   Downstream stage of the decomposed CLA adder. Consumes the non-linear AND terms n[] from the
//   non-linear generator, plus operands a, b and carry-in c. Each carry is the XOR (GF(2) sum)
//   of its term group; sum[j] = a[j]^b[j]^carry[j]. Two-stage pipeline with valid/ready flow

---
 rtl/cla_pkg.sv | 42 ++++
 rtl/cla_linear_part_if.sv | 30 +++
 rtl/cla_group_parity.sv | 26 ++
 rtl/cla_linear_part.sv | 81 ++++++++
 tb/tb_cla_linear_part.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared sizing helpers for the decomposed CLA adder (term layout and chunking).
// No logic; constant functions only, usable from RTL, benches and reference models.
// Group j of the non-linear term vector holds the GF(2) expansion of carry[j+1].
package cla_pkg;

  localparam int NBIT_DEF  = 7;
  localparam int CHUNK_DEF = 8;

  // Total non-linear term count for an nbit adder.
  function automatic int nnl(input int nbit);
    return (1 << (nbit + 2)) - nbit - 4;
  endfunction

  // Bit offset of group j inside the term vector.
  function automatic int grp_off(input int j);
    return (1 << (j + 2)) - j - 4;
  endfunction

  // Number of terms in group j.
  function automatic int grp_len(input int j);
    return (1 << (j + 2)) - 1;
  endfunction

  // Chunks needed to cover group j when each chunk XORs at most 'chunk' terms.
  function automatic int n_chunks(input int j, input int chunk);
    return (grp_len(j) + chunk - 1) / chunk;
  endfunction

  // Position of group j's first chunk parity inside the packed stage-1 register.
  function automatic int chunk_off(input int j, input int chunk);
    int s;
    s = 0;
    for (int i = 0; i < j; i++) s += n_chunks(i, chunk);
    return s;
  endfunction

  // Width of the stage-1 chunk parity register.
  function automatic int total_chunks(input int nbit, input int chunk);
    return chunk_off(nbit, chunk);
  endfunction

endpackage

// File: rtl/cla_linear_part_if.sv
// Handshake bundle between non-linear generator side and consumer of the adder result.
// Input side: in_valid/in_ready with a, b, c, n; output side: out_valid/out_ready with sum, cout.
// master drives inputs and out_ready; slave is the adder stage.
interface cla_linear_part_if #(parameter int NBIT = cla_pkg::NBIT_DEF);
  import cla_pkg::*;

  localparam int NNL = nnl(NBIT);

  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            c;
  logic [NNL-1:0]  n;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] sum;
  logic            cout;

  modport master (
    output in_valid, a, b, c, n, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, c, n, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/cla_group_parity.sv
// Chunked XOR reduction of one carry group: chunk parities in stage 1, their XOR in stage 2.
// Purely combinational, zero latency.
// No flow control; the parent pipeline decides when chunk parities are registered.
module cla_group_parity #(
  parameter int LEN   = 3,
  parameter int CHUNK = 8
) (
  input  logic [LEN-1:0]                   terms,
  output logic [(LEN+CHUNK-1)/CHUNK-1:0]   chunks,
  input  logic [(LEN+CHUNK-1)/CHUNK-1:0]   chunks_q,
  output logic                             carry
);

  localparam int NCH = (LEN + CHUNK - 1) / CHUNK;

  // Last chunk may be shorter than CHUNK when LEN is not a multiple of it.
  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    localparam int LO = k * CHUNK;
    localparam int W  = (LEN - LO < CHUNK) ? (LEN - LO) : CHUNK;
    assign chunks[k] = ^terms[LO +: W];
  end

  // Registered chunk parities fold into the group's carry.
  assign carry = ^chunks_q;

endmodule

// File: rtl/cla_linear_part.sv
// Linear (XOR) half of the decomposed CLA adder: reduces non-linear terms to carries and sums.
// Latency 2 cycles accept-to-out_valid, 1 result per cycle.
// Two-entry valid/ready pipeline; in_ready is the only combinational path (from out_ready).
module cla_linear_part
  import cla_pkg::*;
#(
  parameter int NBIT  = NBIT_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic               clk,
  input logic               rst,
  cla_linear_part_if.slave  bus
);

  localparam int NCHT = total_chunks(NBIT, CHUNK);

  logic            s1_valid;
  logic [NCHT-1:0] p1;
  logic [NCHT-1:0] p1_d;
  logic [NBIT-1:0] prop1;
  logic            c1;
  logic [NBIT:0]   carry;
  logic            out_valid_q;
  logic [NBIT-1:0] sum_q;
  logic            cout_q;
  logic            s2_adv;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;

  assign carry[0] = c1;

  for (genvar j = 0; j < NBIT; j++) begin : g_grp
    cla_group_parity #(
      .LEN   (grp_len(j)),
      .CHUNK (CHUNK)
    ) u_grp (
      .terms    (bus.n[grp_off(j) +: grp_len(j)]),
      .chunks   (p1_d[chunk_off(j, CHUNK) +: n_chunks(j, CHUNK)]),
      .chunks_q (p1[chunk_off(j, CHUNK) +: n_chunks(j, CHUNK)]),
      .carry    (carry[j+1])
    );
  end

  // Stage 1: capture chunk parities, propagate bits and carry-in on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      p1       <= '0;
      prop1    <= '0;
      c1       <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        p1    <= p1_d;
        prop1 <= bus.a ^ bus.b;
        c1    <= bus.c;
      end
    end
  end

  // Stage 2: fold chunks into carries and form sum/cout; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        sum_q  <= prop1 ^ carry[NBIT-1:0];
        cout_q <= carry[NBIT];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_linear_part.sv
// Bench for cla_linear_part: 7-bit instance (CHUNK=8) and 3-bit instance (CHUNK=2).
// Non-linear terms come from a local ANF expansion of the carry-lookahead equations.
// Results are checked through per-instance scoreboards plus directed handshake checks.
module tb_cla_linear_part;
  import cla_pkg::*;

  localparam int NB  = 7;
  localparam int NN  = nnl(NB);
  localparam int NB3 = 3;
  localparam int NN3 = nnl(NB3);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_linear_part_if #(.NBIT(NB))  bus  ();
  cla_linear_part_if #(.NBIT(NB3)) bus3 ();

  cla_linear_part #(.NBIT(NB),  .CHUNK(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  cla_linear_part #(.NBIT(NB3), .CHUNK(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int tests = 0;
  int fails = 0;

  logic [NB:0]  q7[$];
  logic [NB3:0] q3[$];
  logic [NB:0]  exp7;
  logic [NB3:0] exp3;
  int acc7 = 0, res7 = 0, acc3 = 0, res3 = 0;
  logic hold7 = 1'b0, hold3 = 1'b0;
  logic [NB:0]  held7;
  logic [NB3:0] held3;

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    logic       c;
    logic [6:0] sum;
    logic       cout;
  } vec_t;

  // Carry-lookahead expansion over GF(2): for group j, every product g_i * p_(i+1..j)
  // and c * p_(0..j) with each p_k = a_k ^ b_k expanded into a_k or b_k.
  function automatic logic [NN-1:0] gen_terms(input int nbit, input logic [NB-1:0] a,
                                              input logic [NB-1:0] b, input logic c);
    logic [NN-1:0] t;
    int idx;
    logic v;
    t = '0;
    idx = 0;
    for (int j = 0; j < nbit; j++) begin
      for (int i = 0; i <= j; i++) begin
        for (int m = 0; m < (1 << (j - i)); m++) begin
          v = a[i] & b[i];
          for (int k = i + 1; k <= j; k++) v = v & (m[k-i-1] ? b[k] : a[k]);
          t[idx] = v;
          idx++;
        end
      end
      for (int m = 0; m < (1 << (j + 1)); m++) begin
        v = c;
        for (int k = 0; k <= j; k++) v = v & (m[k] ? b[k] : a[k]);
        t[idx] = v;
        idx++;
      end
    end
    return t;
  endfunction

  task automatic drive7(input logic [6:0] a, input logic [6:0] b, input logic c,
                        input logic [7:0] e);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    bus.n = gen_terms(NB, a, b, c);
    exp7 = e;
  endtask

  task automatic drive3(input int idx);
    logic [2:0] a, b;
    logic c;
    logic [NN-1:0] t;
    a = idx[2:0];
    b = idx[5:3];
    c = idx[6];
    t = gen_terms(NB3, {4'b0, a}, {4'b0, b}, c);
    bus3.in_valid = 1'b1;
    bus3.a = a;
    bus3.b = b;
    bus3.c = c;
    bus3.n = t[NN3-1:0];
    exp3 = {1'b0, a} + {1'b0, b} + {3'b0, c};
  endtask

  task automatic check(input string name, input logic ok, input int got, input int want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // One clock: sample at the falling edge, score transfers, then move past the rising edge.
  task automatic step();
    logic [NB:0] e7;
    logic [NB3:0] e3;
    @(negedge clk);
    if (hold7)
      check("hold7", bus.out_valid && ({bus.cout, bus.sum} === held7),
            int'({bus.cout, bus.sum}), int'(held7));
    hold7 = bus.out_valid && !bus.out_ready && !rst;
    held7 = {bus.cout, bus.sum};
    if (hold3)
      check("hold3", bus3.out_valid && ({bus3.cout, bus3.sum} === held3),
            int'({bus3.cout, bus3.sum}), int'(held3));
    hold3 = bus3.out_valid && !bus3.out_ready && !rst;
    held3 = {bus3.cout, bus3.sum};
    if (bus.out_valid && bus.out_ready) begin
      res7++;
      if (q7.size() == 0) begin
        check("sb7_unexpected", 1'b0, int'({bus.cout, bus.sum}), -1);
      end else begin
        e7 = q7.pop_front();
        check("sb7", {bus.cout, bus.sum} === e7, int'({bus.cout, bus.sum}), int'(e7));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      acc7++;
      q7.push_back(exp7);
    end
    if (bus3.out_valid && bus3.out_ready) begin
      res3++;
      if (q3.size() == 0) begin
        check("sb3_unexpected", 1'b0, int'({bus3.cout, bus3.sum}), -1);
      end else begin
        e3 = q3.pop_front();
        check("sb3", {bus3.cout, bus3.sum} === e3, int'({bus3.cout, bus3.sum}), int'(e3));
      end
    end
    if (bus3.in_valid && bus3.in_ready) begin
      acc3++;
      q3.push_back(exp3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain7();
    for (int k = 0; k < 20 && q7.size() != 0; k++) step();
    check("drain7", q7.size() == 0, q7.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int sent, cyc, a0, acc_b, res_b;
    logic need_new;
    logic [6:0] ra, rb;
    logic rc;

    vt[0] = '{7'h7F, 7'h01, 1'b0, 7'h00, 1'b1};
    vt[1] = '{7'h2A, 7'h15, 1'b1, 7'h40, 1'b0};
    vt[2] = '{7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1};
    vt[3] = '{7'h00, 7'h00, 1'b0, 7'h00, 1'b0};
    vt[4] = '{7'h00, 7'h00, 1'b1, 7'h01, 1'b0};
    vt[5] = '{7'h55, 7'h2A, 1'b0, 7'h7F, 1'b0};
    vt[6] = '{7'h55, 7'h2A, 1'b1, 7'h00, 1'b1};
    vt[7] = '{7'h40, 7'h40, 1'b0, 7'h00, 1'b1};
    vt[8] = '{7'h13, 7'h27, 1'b1, 7'h3B, 1'b0};
    vt[9] = '{7'h7F, 7'h00, 1'b1, 7'h00, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = 1'b0; bus.n = '0; bus.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.c = 1'b0; bus3.n = '0;
    bus3.out_ready = 1'b1;
    exp7 = '0;
    exp3 = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state.
    check("rst_out_valid", bus.out_valid === 1'b0, int'(bus.out_valid), 0);
    check("rst_sum_cout", {bus.cout, bus.sum} === 8'h00, int'({bus.cout, bus.sum}), 0);
    check("rst_in_ready", bus.in_ready === 1'b1, int'(bus.in_ready), 1);
    check("rst3_state", {bus3.out_valid, bus3.cout, bus3.sum} === 5'b0,
          int'({bus3.out_valid, bus3.cout, bus3.sum}), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready === 1'b1, int'(bus.in_ready), 1);

    // Single transaction latency.
    bus.out_ready = 1'b1;
    drive7(vt[0].a, vt[0].b, vt[0].c, {vt[0].cout, vt[0].sum});
    step();
    bus.in_valid = 1'b0;
    check("lat_not_yet", bus.out_valid === 1'b0, int'(bus.out_valid), 0);
    step();
    check("lat_out", bus.out_valid === 1'b1 && {bus.cout, bus.sum} === 8'h80,
          int'({bus.out_valid, bus.cout, bus.sum}), 'h180);
    step();

    // Back-to-back table vectors.
    for (int i = 0; i < 10; i++) begin
      drive7(vt[i].a, vt[i].b, vt[i].c, {vt[i].cout, vt[i].sum});
      step();
    end
    bus.in_valid = 1'b0;
    drain7();

    // Random stream with a 4-cycle consumer stall.
    sent = 0; cyc = 0; need_new = 1'b1;
    while ((sent < 10 || q7.size() != 0) && cyc < 300) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 10) begin
        if (need_new) begin
          ra = 7'($urandom_range(0, 127));
          rb = 7'($urandom_range(0, 127));
          rc = 1'($urandom_range(0, 1));
          drive7(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {7'b0, rc});
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (cyc == 6) begin
        #1;
        check("stall_in_ready", bus.in_ready === 1'b0, int'(bus.in_ready), 0);
        check("stall_in_flight", (acc7 - res7) == 2, acc7 - res7, 2);
      end
      a0 = acc7;
      step();
      need_new = (acc7 != a0);
      if (need_new) sent++;
      cyc++;
    end
    check("stream_done", sent == 10 && q7.size() == 0, sent, 10);

    // Both stages full: accept and transfer in the same cycle.
    acc_b = acc7; res_b = res7;
    bus.out_ready = 1'b0;
    drive7(7'h11, 7'h22, 1'b0, 8'h33);
    step();
    drive7(7'h7F, 7'h7F, 1'b0, 8'hFE);
    step();
    drive7(7'h01, 7'h7F, 1'b1, 8'h81);
    bus.out_ready = 1'b1;
    #1;
    check("full_both_hs", bus.in_ready === 1'b1 && bus.out_valid === 1'b1,
          int'({bus.in_ready, bus.out_valid}), 3);
    step();
    bus.in_valid = 1'b0;
    drain7();
    check("full_counts", (acc7 - acc_b) == 3 && (res7 - res_b) == 3, res7 - res_b, 3);

    // Reset with two results in flight.
    drive7(7'h7F, 7'h7F, 1'b1, 8'hFF);
    step();
    drive7(7'h55, 7'h2A, 1'b1, 8'h80);
    step();
    bus.in_valid = 1'b0;
    res_b = res7;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid === 1'b0, int'(bus.out_valid), 0);
    check("mid_rst_sum_cout", {bus.cout, bus.sum} === 8'h00, int'({bus.cout, bus.sum}), 0);
    check("mid_rst_in_ready", bus.in_ready === 1'b1, int'(bus.in_ready), 1);
    q7.delete();
    hold7 = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("rst_dropped", res7 == res_b, res7 - res_b, 0);
    drive7(7'h13, 7'h27, 1'b1, 8'h3B);
    step();
    bus.in_valid = 1'b0;
    drain7();

    // Exhaustive 3-bit instance with random backpressure.
    acc_b = acc3; res_b = res3;
    sent = 0; cyc = 0; need_new = 1'b1;
    while ((sent < 128 || q3.size() != 0) && cyc < 3000) begin
      bus3.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 128) begin
        if (need_new) drive3(sent);
      end else begin
        bus3.in_valid = 1'b0;
      end
      a0 = acc3;
      step();
      need_new = (acc3 != a0);
      if (need_new) sent++;
      cyc++;
    end
    check("exh3_done", sent == 128 && (res3 - res_b) == 128, res3 - res_b, 128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
